// File: rtl/oamdma_responder.sv
// ---------------------------------------------------------------------------
// oamdma_responder
//
// CPU-side responder for the OAM DMA register (FF46). It holds the
// CPU-visible FF46 value apart from the page the DMA controller is actually
// using. It queues a restart when FF46 is written mid-transfer. While a
// transfer runs it remaps the source address, latches the fetched byte and
// drives the OAM write port. It also decides which CPU accesses are
// overridden or blocked during DMA or PPU OAM ownership.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   cpu_en                clock-enable tick; state advances only when high
//   cpu_addr/cpu_wdata    CPU bus address / write data
//   cpu_write/cpu_read    CPU access strobes
//   ppu_oam_busy          PPU currently owns OAM
//   oamdma                transfer active (from DMA controller)
//   oamdma_src_addr       DMA source address (from DMA controller)
//   oamdma_oam_addr       DMA destination index (from DMA controller)
//   oamdma_write          DMA write phase (from DMA controller)
//   ext_rdata             memory-system read data for bus_addr
//   oamdma_start_addr     active source page to DMA controller
//   oamdma_start          start request to DMA controller
//   oamdma_done           one-cycle pulse when the transfer ends
//   bus_addr              address driven to the memory system
//   cpu_rdata_ovr_en/ovr  force CPU read data
//   cpu_write_block       suppress CPU write to the memory system
//   oam_we/addr/wdata     OAM RAM write port
// ---------------------------------------------------------------------------
module oamdma_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_write,
  input  logic        cpu_read,
  input  logic        ppu_oam_busy,
  input  logic        oamdma,
  input  logic [15:0] oamdma_src_addr,
  input  logic [7:0]  oamdma_oam_addr,
  input  logic        oamdma_write,
  input  logic [7:0]  ext_rdata,
  output logic [7:0]  oamdma_start_addr,
  output logic        oamdma_start,
  output logic        oamdma_done,
  output logic [15:0] bus_addr,
  output logic        cpu_rdata_ovr_en,
  output logic [7:0]  cpu_rdata_ovr,
  output logic        cpu_write_block,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata
);

  logic [7:0] ff46_reg;
  logic [7:0] active_base;
  logic [7:0] latch;
  logic       pending;
  logic       start_q;
  logic       oamdma_q;

  // Address decode of the CPU bus.
  logic is_ff46;
  logic in_oam;     // FE00-FE9F
  logic in_unused;  // FEA0-FEFF
  logic in_hi;      // FF00-FFFE, still reachable during DMA
  logic dma_block;

  assign is_ff46   = (cpu_addr == 16'hFF46);
  assign in_oam    = (cpu_addr[15:8] == 8'hFE) && (cpu_addr[7:0] < 8'hA0);
  assign in_unused = (cpu_addr[15:8] == 8'hFE) && (cpu_addr[7:0] >= 8'hA0);
  assign in_hi     = (cpu_addr[15:8] == 8'hFF) && (cpu_addr != 16'hFFFF);
  assign dma_block = oamdma && !in_hi;

  // A launch happens on an idle tick when FF46 is written now or a write
  // was queued during the previous transfer. A same-tick write wins over the
  // queued value so the most recent CPU intent is used.
  logic       ff46_wr;
  logic       launch;
  logic [7:0] launch_base;

  assign ff46_wr     = cpu_en && cpu_write && is_ff46;
  assign launch      = cpu_en && !oamdma && (ff46_wr || pending);
  assign launch_base = ff46_wr ? cpu_wdata : ff46_reg;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ff46_reg    <= 8'h00;
      active_base <= 8'h00;
      latch       <= 8'h00;
      pending     <= 1'b0;
      start_q     <= 1'b0;
      oamdma_q    <= 1'b0;
    end else begin
      // Edge detect runs on every clk so the done pulse is one clk wide.
      oamdma_q <= oamdma;

      if (ff46_wr)
        ff46_reg <= cpu_wdata;

      if (launch) begin
        active_base <= launch_base;
        pending     <= 1'b0;
      end else if (ff46_wr && oamdma) begin
        pending <= 1'b1;
      end

      // Start rises after the launching tick and stays up through the next
      // cpu_en tick, so the controller sees it on its own enable.
      if (cpu_en)
        start_q <= launch;

      if (cpu_en && oamdma && !oamdma_write)
        latch <= ext_rdata;
    end
  end

  assign oamdma_start_addr = active_base;
  assign oamdma_start      = start_q;
  assign oamdma_done       = oamdma_q && !oamdma && !reset;

  // Echo RAM (E000-FFFF) folds back onto C000-DFFF for DMA sources.
  logic [7:0] src_hi;
  assign src_hi   = (oamdma_src_addr[15:8] >= 8'hE0) ? (oamdma_src_addr[15:8] - 8'h20)
                                                     : oamdma_src_addr[15:8];
  assign bus_addr = oamdma ? {src_hi, oamdma_src_addr[7:0]} : cpu_addr;

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    cpu_rdata_ovr_en = 1'b0;
    cpu_rdata_ovr    = 8'h00;
    cpu_write_block  = 1'b0;
    oam_we           = 1'b0;
    oam_addr         = 8'h00;
    oam_wdata        = 8'h00;

    if (cpu_read) begin
      if (is_ff46) begin
        cpu_rdata_ovr_en = 1'b1;
        cpu_rdata_ovr    = ff46_reg;
      end else if (dma_block || (!oamdma && in_oam && ppu_oam_busy)) begin
        cpu_rdata_ovr_en = 1'b1;
        cpu_rdata_ovr    = 8'hFF;
      end else if (in_unused) begin
        cpu_rdata_ovr_en = 1'b1;
        cpu_rdata_ovr    = 8'h00;
      end
    end

    if (cpu_write && (dma_block || (!oamdma && in_oam && ppu_oam_busy)))
      cpu_write_block = 1'b1;

    // The DMA owns the OAM port for the whole transfer.
    if (oamdma) begin
      oam_we    = cpu_en && oamdma_write;
      oam_addr  = oamdma_oam_addr;
      oam_wdata = latch;
    end else if (cpu_write && in_oam && !ppu_oam_busy) begin
      oam_we    = cpu_en;
      oam_addr  = cpu_addr[7:0];
      oam_wdata = cpu_wdata;
    end
  end

endmodule

// File: doc/oamdma_responder.md
OAMDMA_RESPONDER -- requirements
Module: oamdma_responder

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset; clock clk.
REQ-003 cpu_en  in  1  clock-enable tick; state advances only on cycles with cpu_en=1.
REQ-004 cpu_addr  in  16  CPU bus address.
REQ-005 cpu_wdata  in  8  CPU write data.
REQ-006 cpu_write / cpu_read  in  1 each  CPU access strobes.
REQ-007 ppu_oam_busy  in  1  PPU owns OAM (modes 2/3).
REQ-008 oamdma  in  1  transfer active, from DMA controller.
REQ-009 oamdma_src_addr  in  16  DMA source address, from DMA controller.
REQ-010 oamdma_oam_addr  in  8  DMA destination index, from DMA controller.
REQ-011 oamdma_write  in  1  DMA write phase, from DMA controller.
REQ-012 ext_rdata  in  8  memory-system read data for bus_addr.
REQ-013 oamdma_start_addr  out  8  active source page to DMA controller.
REQ-014 oamdma_start  out  1  start request to DMA controller.
REQ-015 oamdma_done  out  1  one-cycle pulse at transfer end.
REQ-016 bus_addr  out  16  address driven to memory system.
REQ-017 cpu_rdata_ovr_en / cpu_rdata_ovr  out  1 / 8  force CPU read data.
REQ-018 cpu_write_block  out  1  suppress CPU write to memory system.
REQ-019 oam_we / oam_addr / oam_wdata  out  1 / 8 / 8  OAM RAM write port.

Function
REQ-020 The block SHALL hold ff46_reg (CPU-visible) and active_base (drives oamdma_start_addr) as separate 8-bit registers.
REQ-021 On a cpu_en cycle with cpu_write and cpu_addr=FF46, the block SHALL load ff46_reg<=cpu_wdata.
- Idle (oamdma=0, no pending): also active_base<=cpu_wdata; oamdma_start=1 on the following cycle, held until and including the next cpu_en cycle, then 0.
- Active (oamdma=1): set pending=1; active_base unchanged; no start.
REQ-022 Repeated FF46 writes while pending SHALL leave pending=1; last value wins.
REQ-023 On the first cpu_en cycle with pending=1 and oamdma=0, the block SHALL load active_base<=ff46_reg, clear pending, and issue oamdma_start exactly as in REQ-021 (idle case).
REQ-024 CPU read of FF46 SHALL return ff46_reg via the override (ovr_en=1) at all times, DMA or not.
REQ-025 bus_addr SHALL be the remapped oamdma_src_addr while oamdma=1, else cpu_addr.
- Remap: high byte E0-FF maps to high byte minus 0x20; low byte unchanged.
REQ-026 Data latch: on cpu_en cycles with oamdma=1 and oamdma_write=0, the block SHALL capture ext_rdata; the last capture before a write phase is the byte written.
REQ-027 oam_we SHALL equal cpu_en & oamdma & oamdma_write (combinational, same cycle).
- oam_addr=oamdma_oam_addr; oam_wdata=latch.
REQ-028 While oamdma=1, CPU access outside FF00-FFFE SHALL be blocked.
- Reads: ovr_en=1, ovr=FF.
- Writes: cpu_write_block=1.
- FF46 stays accessible per REQ-021/024.
REQ-029 While oamdma=0, a CPU write to FE00-FE9F SHALL produce oam_we=cpu_en, oam_addr=cpu_addr[7:0], oam_wdata=cpu_wdata, unless ppu_oam_busy=1 (then dropped, cpu_write_block=1).
REQ-030 While oamdma=0 and ppu_oam_busy=1, CPU reads of FE00-FE9F SHALL return FF via the override.
REQ-031 CPU reads of FEA0-FEFF SHALL return 00 via the override when not blocked.
REQ-032 oamdma_done SHALL pulse high for one clk cycle on the first cycle after oamdma is sampled falling (registered previous value).
REQ-033 Override, block and oam_* outputs SHALL be combinational; registers are ff46_reg, active_base, pending, start, latch, oamdma_q.

Reset
REQ-034 While reset=1, ff46_reg, active_base and the latch SHALL be 00; pending, oamdma_start, oamdma_done and oamdma_q SHALL be 0.
REQ-035 Reset SHALL override cpu_en, and a reset mid-transfer SHALL discard pending and any start in flight.

Verification
REQ-036 Idle write FF46=C1 -> oamdma_start pulse; oamdma_start_addr=C1; ext_rdata=5A at src C100 -> oam_we with oam_addr=00, oam_wdata=5A.
REQ-037 Start page E2 -> bus_addr=C2xx during DMA.
REQ-038 During DMA: CPU read C000 -> ovr=FF; CPU write 8000 -> cpu_write_block=1; CPU write FF80 -> not blocked.
REQ-039 During DMA write FF46=C3 then C4 -> FF46 reads C4; at DMA end, oamdma_done pulse, then start with active_base=C4.
REQ-040 No DMA, ppu_oam_busy=1: write FE10 -> oam_we=0; read FE10 -> FF; with ppu_oam_busy=0, write FE10=77 -> oam_we=1, oam_addr=10, oam_wdata=77.
REQ-041 Reset asserted with pending=1 mid-DMA -> all registers 00/0; no start after oamdma falls.
